prng_req_scheduler: RTL
=======================

# prng_req_scheduler

Controller that owns the 64-bit four-lane pseudo-random generator state and shares it among N_REQ requesters. It sequences seeding, warm-up and round-robin service, and hands out one 64-bit word per grant. It sits between the seed source (host/config side) and the blocks consuming random words. It replaces free-running generators that every consumer would otherwise have to instantiate.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WARMUP_CYCLES, 64, generator steps discarded after each seed load (0 allowed)
- RESEED_INTERVAL, 1024, grants between forced reseeds (used only with PRNG_RESEED_EN)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- seed  in  64  seed word, lanes [15:0],[31:16],[47:32],[63:48]
- seed_valid  in  1  seed offered
- seed_ready  out  1  block accepts seed this cycle
- req  in  N_REQ  level request, one bit per requester
- gnt  out  N_REQ  registered one-hot grant pulse
- rnd_valid  out  1  registered, high with any gnt bit
- rnd_data  out  64  word for the granted requester, valid while rnd_valid
- serving  out  1  high in SERVE state

## Operation
- FSM states: WAIT_SEED, WARMUP, SERVE. Reset enters WAIT_SEED.
- Seed handshake: seed_ready = 1 in WAIT_SEED and SERVE, 0 in WARMUP. Fire = seed_valid & seed_ready.
- On fire: each 16-bit lane loads from seed. A zero lane loads LANE_NONZERO (16'h0001) instead. Warm-up counter clears. Next state is WARMUP, or SERVE if WARMUP_CYCLES = 0.
- Lane step, applied to all four lanes at once: lane <= {lane[14:0], lane[3]^lane[12]^lane[14]^lane[15]}.
- WARMUP: the state steps every cycle. After WARMUP_CYCLES steps, go to SERVE. No grants are issued.
- SERVE: if req != 0 and no seed fire, grant exactly one requester per cycle, round-robin:
  - Search starts at pointer p and goes upward with wrap.
  - After a grant to i, p <= (i+1) mod N_REQ.
  - p resets to 0 and does not change on reseed.
- Grant cycle: rnd_data <= current state, then the state steps once. No step occurs in SERVE without a grant.
- A seed fire and a pending request in the same SERVE cycle: the seed wins, there is no grant, and the request remains pending.
- Requesters hold req until they see gnt. Each gnt pulse delivers one word. A requester wanting more keeps req high and may be granted every cycle if it is the only requester.
- Asserting reset in any state clears everything immediately; in-flight warm-up is discarded.

## Timing
- Reset values:
  - gnt = 0, rnd_valid = 0, rnd_data = 0, serving = 0, seed_ready = 1.
  - State lanes = 0, p = 0, counters = 0.
- Request-to-grant latency: req sampled at edge t produces gnt/rnd_valid/rnd_data visible after edge t, for one cycle. The minimum latency is 1 cycle.
- Seed fire at edge t: serving rises after edge t + WARMUP_CYCLES. The earliest grant is at the following edge.
- Throughput: one word per cycle in SERVE.
- gnt is zero-or-one-hot. rnd_valid equals |gnt.

## Configuration
- PRNG_RESEED_EN defined:
  - A grant counter counts grants since the last seed load.
  - When it reaches RESEED_INTERVAL, the FSM moves to WAIT_SEED right after that grant; serving drops and grants stall until a new seed fires.
  - The counter clears on seed fire.
- PRNG_RESEED_EN undefined: no counter and no forced reseed. SERVE persists until reset or a voluntary seed.

## Structure
- Package prng_pkg:
  - state enum (WAIT_SEED, WARMUP, SERVE), LANE_W = 16, NUM_LANES = 4, LANE_NONZERO.
  - Function lane_step(lane) and function state_step(64-bit).
- Sub-module rr_arbiter: parameter N, inputs req, pointer and enable; outputs a combinational one-hot gnt_next and the index.
- Top holds the FSM, state register, counters and output registers.

## Test plan
- Reset with WARMUP_CYCLES = 0: outputs at reset values, seed_ready = 1. Seed 64'h8000_8000_8000_8000 fires, serving rises next cycle.
- WARMUP_CYCLES = 0, seed 64'h8000_8000_8000_8000, only req[0] high:
  - First word is 64'h8000_8000_8000_8000.
  - Second is 64'h0001_0001_0001_0001.
  - Third is 64'h0002_0002_0002_0002, with gnt = 0001 on three consecutive cycles.
- Seed 64'h0 with warm-up 0: first word is 64'h0001_0001_0001_0001 (lane lockup guard).
- req = 4'b1111 held: gnt sequence 0001, 0010, 0100, 1000, 0001; then req = 4'b1010 yields 0010, 1000, 0010.
- Seed fire during SERVE with req high: no gnt that cycle, then WARMUP of 64 cycles with no grants, then service resumes at the unchanged pointer.
- With PRNG_RESEED_EN and RESEED_INTERVAL = 4: after 4 grants, serving drops and seed_ready = 1, with no further grants until a seed fires. Reset mid-WARMUP returns to WAIT_SEED with all outputs cleared.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg: shared types, lane constants and step/seed helpers for prng_req_scheduler
package prng_pkg;
   localparam int LANE_W = 16;
   localparam int NUM_LANES = 4;
   localparam logic [LANE_W-1:0] LANE_NONZERO = 16'h0001;
   typedef enum logic [1:0] {WAIT_SEED, WARMUP, SERVE} state_e;
   function automatic logic [LANE_W-1:0] lane_step(input logic [LANE_W-1:0] lane);
      return {lane[14:0], lane[3] ^ lane[12] ^ lane[14] ^ lane[15]};
   endfunction
   function automatic logic [LANE_W*NUM_LANES-1:0] state_step(input logic [LANE_W*NUM_LANES-1:0] s);
      logic [LANE_W*NUM_LANES-1:0] r;
      for (int i = 0; i < NUM_LANES; i++) r[i*LANE_W +: LANE_W] = lane_step(s[i*LANE_W +: LANE_W]);
      return r;
   endfunction
   // an all-zero lane would never leave zero, so it is replaced on load
   function automatic logic [LANE_W*NUM_LANES-1:0] seed_load(input logic [LANE_W*NUM_LANES-1:0] s);
      logic [LANE_W*NUM_LANES-1:0] r;
      for (int i = 0; i < NUM_LANES; i++)
         r[i*LANE_W +: LANE_W] = s[i*LANE_W +: LANE_W] == '0 ? LANE_NONZERO : s[i*LANE_W +: LANE_W];
      return r;
   endfunction
endpackage

// File: rtl/prng_req_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, searching upward with wrap
//   req      : request vector
//   ptr      : index with highest priority
//   en       : allows a grant
//   gnt_next : one-hot (or zero) grant
//   idx      : index of the granted bit
module rr_arbiter #(
   parameter int N = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt_next,
   output logic [PW-1:0] idx
);
   // descending offsets so the closest requester above ptr is the last write
   always_comb begin
      gnt_next = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (en && req[(int'(ptr) + k) % N]) begin
            gnt_next = N'(1) << ((int'(ptr) + k) % N);
            idx = PW'((int'(ptr) + k) % N);
         end
   end
endmodule

// File: rtl/prng_req_scheduler.sv
// prng_req_scheduler: seeds, warms up and shares a four-lane 64-bit PRNG among N_REQ requesters
//   clk, reset (async, active low)
//   seed/seed_valid/seed_ready : seed handshake, loads lanes and restarts warm-up
//   req   : level requests        gnt : registered one-hot grant pulse
//   rnd_valid/rnd_data : word delivered with gnt
//   serving : high in SERVE
//   PRNG_RESEED_EN : when defined, forces WAIT_SEED after RESEED_INTERVAL grants
module prng_req_scheduler
   import prng_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WARMUP_CYCLES = 64,
   parameter int RESEED_INTERVAL = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      seed,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             rnd_valid,
   output logic [63:0]      rnd_data,
   output logic             serving
);
   localparam int PW = $clog2(N_REQ);
   localparam int WCW = $clog2(WARMUP_CYCLES + 1) + 1;
   state_e state_q, state_d;
   logic [63:0] lanes_q, lanes_d, rnd_data_q, rnd_data_d;
   logic [PW-1:0] ptr_q, ptr_d, idx;
   logic [WCW-1:0] warm_q, warm_d;
   logic [N_REQ-1:0] gnt_q, gnt_next;
   logic rnd_valid_q, fire, grant;
`ifdef PRNG_RESEED_EN
   localparam int RCW = $clog2(RESEED_INTERVAL + 1) + 1;
   logic [RCW-1:0] rs_q, rs_d;
`endif
   assign seed_ready = state_q != WARMUP;
   assign fire = seed_valid & seed_ready;
   assign grant = |gnt_next;
   assign gnt = gnt_q;
   assign rnd_valid = rnd_valid_q;
   assign rnd_data = rnd_data_q;
   assign serving = state_q == SERVE;
   // a seed fire in SERVE takes the cycle, so the arbiter is held off
   rr_arbiter #(.N(N_REQ)) u_arb (
      .req(req),
      .ptr(ptr_q),
      .en(state_q == SERVE && !fire),
      .gnt_next(gnt_next),
      .idx(idx)
   );
   always_comb begin
      state_d = state_q;
      lanes_d = lanes_q;
      ptr_d = ptr_q;
      warm_d = warm_q;
      rnd_data_d = grant ? lanes_q : rnd_data_q;
`ifdef PRNG_RESEED_EN
      rs_d = rs_q;
`endif
      if (fire) begin
         lanes_d = seed_load(seed);
         warm_d = '0;
         state_d = WARMUP_CYCLES == 0 ? SERVE : WARMUP;
`ifdef PRNG_RESEED_EN
         rs_d = '0;
`endif
      end else if (state_q == WARMUP) begin
         lanes_d = state_step(lanes_q);
         warm_d = warm_q + 1'b1;
         state_d = warm_q == WCW'(WARMUP_CYCLES - 1) ? SERVE : WARMUP;
      end else if (grant) begin
         lanes_d = state_step(lanes_q);
         ptr_d = idx == PW'(N_REQ - 1) ? '0 : idx + 1'b1;
`ifdef PRNG_RESEED_EN
         rs_d = rs_q + 1'b1;
         state_d = rs_d == RCW'(RESEED_INTERVAL) ? WAIT_SEED : SERVE;
`endif
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= WAIT_SEED;
         lanes_q <= '0;
         ptr_q <= '0;
         warm_q <= '0;
         gnt_q <= '0;
         rnd_valid_q <= 1'b0;
         rnd_data_q <= '0;
`ifdef PRNG_RESEED_EN
         rs_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         lanes_q <= lanes_d;
         ptr_q <= ptr_d;
         warm_q <= warm_d;
         gnt_q <= gnt_next;
         rnd_valid_q <= grant;
         rnd_data_q <= rnd_data_d;
`ifdef PRNG_RESEED_EN
         rs_q <= rs_d;
`endif
      end
endmodule
